// File: rtl/id_ex_pipe_pkg.sv
// Shared encodings for the ID/EX stage: write-back selects, bubble constants and halt states.
package id_ex_pipe_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_PC4   = 2'b01;
    localparam logic [1:0] WB_MEM   = 2'b10;
    localparam logic [1:0] WB_AUIPC = 2'b11;

    // A bubble is an all-zero slot: no control bit set, ALU op class 00, ALU write-back.
    localparam logic       BUBBLE_CTRL   = 1'b0;
    localparam logic [1:0] BUBBLE_ALU_OP = 2'b00;
    localparam logic [1:0] BUBBLE_WB     = WB_ALU;
    localparam logic [4:0] BUBBLE_REG    = 5'd0;

    typedef enum logic {
        HS_RUN  = 1'b0,
        HS_HALT = 1'b1
    } halt_state_e;

endpackage

// File: rtl/id_ex_pipe_hazard.sv
// Load-use hazard detection: a load in EX whose destination feeds either source of the ID instruction.
module hazard_detect (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       hz
);
    // Both source fields are compared regardless of opcode; a spurious stall only costs a cycle.
    assign hz = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid
              & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall, flush-on-redirect and the sticky SYSTEM/FENCE halt latch.
module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic            id_branch,
    input  logic            id_mem_read,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_write,
    input  logic            id_jalr,
    input  logic            id_jal,
    input  logic            id_lui,
    input  logic            id_halt,
    input  logic [1:0]      id_alu_op,
    input  logic [1:0]      id_write_back,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7b5,
    input  logic            flush,
    output logic            ex_valid,
    output logic            ex_branch,
    output logic            ex_mem_read,
    output logic            ex_alu_src,
    output logic            ex_reg_write,
    output logic            ex_mem_write,
    output logic            ex_jalr,
    output logic            ex_jal,
    output logic            ex_lui,
    output logic            ex_halt,
    output logic [1:0]      ex_alu_op,
    output logic [1:0]      ex_write_back,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            stall,
    output logic            halted
);

    halt_state_e state, state_next;
    logic        hz;
    logic        bubble;

    hazard_detect u_hazard (
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .hz          (hz)
    );

    assign halted = (state == HS_HALT);
    // While halted fetch is already frozen, so holding IF/ID would be redundant.
    assign stall  = hz & ~flush & ~halted;
    assign bubble = halted | flush | hz | ~id_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= HS_RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == HS_RUN && ex_valid && ex_halt) state_next = HS_HALT;
    end

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            ex_valid      <= 1'b0;
            ex_branch     <= BUBBLE_CTRL;
            ex_mem_read   <= BUBBLE_CTRL;
            ex_alu_src    <= BUBBLE_CTRL;
            ex_reg_write  <= BUBBLE_CTRL;
            ex_mem_write  <= BUBBLE_CTRL;
            ex_jalr       <= BUBBLE_CTRL;
            ex_jal        <= BUBBLE_CTRL;
            ex_lui        <= BUBBLE_CTRL;
            ex_halt       <= BUBBLE_CTRL;
            ex_alu_op     <= BUBBLE_ALU_OP;
            ex_write_back <= BUBBLE_WB;
            ex_pc         <= '0;
            ex_rs1_data   <= '0;
            ex_rs2_data   <= '0;
            ex_imm        <= '0;
            ex_rs1        <= BUBBLE_REG;
            ex_rs2        <= BUBBLE_REG;
            ex_rd         <= BUBBLE_REG;
            ex_funct3     <= 3'd0;
            ex_funct7b5   <= 1'b0;
        end else begin
            ex_valid      <= 1'b1;
            ex_branch     <= id_branch;
            ex_mem_read   <= id_mem_read;
            ex_alu_src    <= id_alu_src;
            ex_reg_write  <= id_reg_write;
            ex_mem_write  <= id_mem_write;
            ex_jalr       <= id_jalr;
            ex_jal        <= id_jal;
            ex_lui        <= id_lui;
            ex_halt       <= id_halt;
            ex_alu_op     <= id_alu_op;
            ex_write_back <= id_write_back;
            ex_pc         <= id_pc;
            ex_rs1_data   <= id_rs1_data;
            ex_rs2_data   <= id_rs2_data;
            ex_imm        <= id_imm;
            ex_rs1        <= id_rs1;
            ex_rs2        <= id_rs2;
            ex_rd         <= id_rd;
            ex_funct3     <= id_funct3;
            ex_funct7b5   <= id_funct7b5;
        end
    end

endmodule
